// File: rtl/tour_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tour_pkg
// Description : Shared opcodes, headings, response codes and the state type
//               for the knight's-tour command initiator.
// Revision    : 1.0 - initial release
// ============================================================================
package tour_pkg;

  // Command opcodes (cmd[15:12])
  localparam logic [3:0] OP_MOVE    = 4'h4;
  localparam logic [3:0] OP_MOVE_FF = 4'h5;

  // Headings (cmd[11:4])
  localparam logic [7:0] HDG_N = 8'h00;
  localparam logic [7:0] HDG_W = 8'h3F;
  localparam logic [7:0] HDG_S = 8'h7F;
  localparam logic [7:0] HDG_E = 8'hBF;

  // Response bytes returned to the UART side
  localparam logic [7:0] RESP_ACK = 8'hA5;
  localparam logic [7:0] RESP_POS = 8'h5A;
  localparam logic [7:0] RESP_ERR = 8'hEE;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    VERT   = 3'd1,
    WAIT_V = 3'd2,
    HORZ   = 3'd3,
    WAIT_H = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/tour_cmd_if.sv
`default_nettype none
// ============================================================================
// Module      : tour_cmd_if
// Description : Command/response handshake between the command initiator
//               (master) and cmd_proc (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface tour_cmd_if;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        send_resp;

  modport master (output cmd, cmd_rdy, input clr_cmd_rdy, send_resp);
  modport slave  (input cmd, cmd_rdy, output clr_cmd_rdy, send_resp);
endinterface
`default_nettype wire

// File: rtl/tour_cmd_knight_move_decode.sv
`default_nettype none
// ============================================================================
// Module      : knight_move_decode
// Description : Splits a one-hot knight move into a vertical leg and a
//               horizontal leg (heading + square count). Lowest set bit wins.
// Revision    : 1.0 - initial release
// ============================================================================
module knight_move_decode
  import tour_pkg::*;
(
  input  wire logic [7:0] i_move,
  output logic            o_valid,
  output logic [7:0]      o_v_hdg,
  output logic [3:0]      o_v_cnt,
  output logic [7:0]      o_h_hdg,
  output logic [3:0]      o_h_cnt
);

  logic [2:0] w_bit;

  // Priority-select the lowest set bit, then look up both legs for it
  always_comb begin
    w_bit = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (i_move[i]) w_bit = 3'(i);
    end
    o_valid = |i_move;
    o_v_hdg = HDG_N;
    o_v_cnt = 4'd1;
    o_h_hdg = HDG_E;
    o_h_cnt = 4'd1;
    case (w_bit)
      3'd0: begin o_v_hdg = HDG_N; o_v_cnt = 4'd2; o_h_hdg = HDG_E; o_h_cnt = 4'd1; end
      3'd1: begin o_v_hdg = HDG_N; o_v_cnt = 4'd2; o_h_hdg = HDG_W; o_h_cnt = 4'd1; end
      3'd2: begin o_v_hdg = HDG_N; o_v_cnt = 4'd1; o_h_hdg = HDG_W; o_h_cnt = 4'd2; end
      3'd3: begin o_v_hdg = HDG_S; o_v_cnt = 4'd1; o_h_hdg = HDG_W; o_h_cnt = 4'd2; end
      3'd4: begin o_v_hdg = HDG_S; o_v_cnt = 4'd2; o_h_hdg = HDG_W; o_h_cnt = 4'd1; end
      3'd5: begin o_v_hdg = HDG_S; o_v_cnt = 4'd2; o_h_hdg = HDG_E; o_h_cnt = 4'd1; end
      3'd6: begin o_v_hdg = HDG_S; o_v_cnt = 4'd1; o_h_hdg = HDG_E; o_h_cnt = 4'd2; end
      default: begin o_v_hdg = HDG_N; o_v_cnt = 4'd1; o_h_hdg = HDG_E; o_h_cnt = 4'd2; end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/tour_cmd.sv
`default_nettype none
// ============================================================================
// Module      : tour_cmd
// Description : Command initiator for cmd_proc. Passes UART commands through
//               when idle; after start_tour replays the stored knight's tour
//               as vertical/horizontal command pairs.
// Revision    : 1.0 - initial release
// ============================================================================
module tour_cmd
  import tour_pkg::*;
#(
  parameter int NUM_MOVES = 24
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  input  wire logic        start_tour,
  input  wire logic [7:0]  move,
  output logic [4:0]       mv_indx,
  input  wire logic [15:0] cmd_UART,
  input  wire logic        cmd_rdy_UART,
  output logic             clr_cmd_rdy_UART,
  tour_cmd_if.master       cp,
  output logic             send_resp_UART,
  output logic [7:0]       resp
);

  localparam logic [4:0] LAST_IDX = 5'(NUM_MOVES - 1);

  state_t     r_state;
  logic [4:0] r_mv_indx;
  logic       r_srsp;
  logic [7:0] r_resp;

  logic       w_valid;
  logic [7:0] w_v_hdg;
  logic [3:0] w_v_cnt;
  logic [7:0] w_h_hdg;
  logic [3:0] w_h_cnt;
  logic       w_idle;

  knight_move_decode u_dec (
    .i_move  (move),
    .o_valid (w_valid),
    .o_v_hdg (w_v_hdg),
    .o_v_cnt (w_v_cnt),
    .o_h_hdg (w_h_hdg),
    .o_h_cnt (w_h_cnt)
  );

  // Tour sequencer: state, move index and the one-cycle response strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_mv_indx <= 5'd0;
      r_srsp    <= 1'b0;
      r_resp    <= RESP_ACK;
    end else begin
      r_srsp <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start_tour) begin
            r_mv_indx <= 5'd0;
            r_state   <= VERT;
          end
        end
        VERT: begin
          // An empty move slot means the stored tour is broken: abort
          if (!w_valid) begin
            r_state <= IDLE;
            r_srsp  <= 1'b1;
            r_resp  <= RESP_ERR;
          end else if (cp.clr_cmd_rdy) begin
            r_state <= WAIT_V;
          end
        end
        WAIT_V: begin
          if (cp.send_resp) r_state <= HORZ;
        end
        HORZ: begin
          if (cp.clr_cmd_rdy) r_state <= WAIT_H;
        end
        WAIT_H: begin
          if (cp.send_resp) begin
            r_srsp <= 1'b1;
            if (r_mv_indx == LAST_IDX) begin
              r_resp  <= RESP_ACK;
              r_state <= IDLE;
            end else begin
              r_resp    <= RESP_POS;
              r_mv_indx <= r_mv_indx + 5'd1;
              r_state   <= VERT;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Output mux: UART passthrough when idle, state-decoded commands on tour
  always_comb begin
    w_idle           = (r_state == IDLE);
    cp.cmd           = cmd_UART;
    cp.cmd_rdy       = cmd_rdy_UART;
    clr_cmd_rdy_UART = w_idle & cp.clr_cmd_rdy;
    send_resp_UART   = r_srsp | (w_idle & cp.send_resp);
    resp             = r_srsp ? r_resp : RESP_ACK;
    if (!w_idle) begin
      if (r_state == VERT || r_state == WAIT_V) begin
        cp.cmd = {OP_MOVE, w_v_hdg, w_v_cnt};
      end else begin
        cp.cmd = {OP_MOVE_FF, w_h_hdg, w_h_cnt};
      end
      cp.cmd_rdy = (r_state == HORZ) | ((r_state == VERT) & w_valid);
    end
  end

  assign mv_indx = r_mv_indx;

endmodule
`default_nettype wire

// File: tb/tb_tour_cmd.sv
`default_nettype none
// ============================================================================
// Module      : tb_tour_cmd
// Description : Randomized bench for tour_cmd with a cmd_proc model and a
//               knight-geometry reference for the expected command stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tour_cmd;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_tour = 1'b0;
  logic [7:0]  move;
  logic [4:0]  mv_indx;
  logic [15:0] cmd_UART = 16'h0;
  logic        cmd_rdy_UART = 1'b0;
  logic        clr_cmd_rdy_UART;
  logic        send_resp_UART;
  logic [7:0]  resp;
  logic [7:0]  tour_moves [0:31];

  tour_cmd_if cp ();

  assign move = tour_moves[mv_indx];

  tour_cmd #(.NUM_MOVES(24)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start_tour       (start_tour),
    .move             (move),
    .mv_indx          (mv_indx),
    .cmd_UART         (cmd_UART),
    .cmd_rdy_UART     (cmd_rdy_UART),
    .clr_cmd_rdy_UART (clr_cmd_rdy_UART),
    .cp               (cp),
    .send_resp_UART   (send_resp_UART),
    .resp             (resp)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] cmd_q [$];
  logic [7:0]  resp_q [$];
  int          idx_q [$];
  logic [15:0] obs_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: knight displacement (rows up, columns right) per move bit
  function automatic void model_legs(input logic [7:0] m, output logic [15:0] vc,
                                     output logic [15:0] hc);
    int dys [8] = '{2, 2, 1, -1, -2, -2, -1, 1};
    int dxs [8] = '{1, -1, -2, -2, -1, 1, 2, 2};
    int dy = 0;
    int dx = 0;
    bit found = 0;
    for (int i = 0; i < 8; i++) begin
      if (m[i] && !found) begin
        dy = dys[i];
        dx = dxs[i];
        found = 1;
      end
    end
    vc = {4'h4, (dy > 0) ? 8'h00 : 8'h7F, 4'((dy < 0) ? -dy : dy)};
    hc = {4'h5, (dx > 0) ? 8'hBF : 8'h3F, 4'((dx < 0) ? -dx : dx)};
  endfunction

  task automatic build_expect();
    logic [15:0] vc, hc;
    cmd_q.delete(); resp_q.delete(); idx_q.delete();
    for (int i = 0; i < 24; i++) begin
      if (tour_moves[i] == 8'h00) begin
        resp_q.push_back(8'hEE); idx_q.push_back(i);
        return;
      end
      model_legs(tour_moves[i], vc, hc);
      cmd_q.push_back(vc); cmd_q.push_back(hc);
      if (i == 23) begin resp_q.push_back(8'hA5); idx_q.push_back(23); end
      else begin resp_q.push_back(8'h5A); idx_q.push_back(i + 1); end
    end
  endtask

  task automatic do_reset();
    cmd_rdy_UART = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_cmd_rdy", cp.cmd_rdy, 1'b0);
    chk("async_rst_mv_indx", mv_indx, 5'd0);
    chk("async_rst_resp", resp, 8'hA5);
    chk("async_rst_send_resp_UART", send_resp_UART, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Runs one tour against the cmd_proc model; rst_leg >= 0 resets at that leg
  task automatic run_tour(input int rst_leg);
    int phase = 0;
    int dly = 0;
    int legs = 0;
    int exp_idx = 0;
    int cyc = 0;
    bit done = 0;
    logic [15:0] cur = 16'h0;
    build_expect();
    obs_q.delete();
    start_tour = 1'b1;
    @(posedge clk); #1;
    start_tour = 1'b0;
    while (!done && cyc < 3000) begin
      cyc++;
      if (send_resp_UART) begin
        if (resp_q.size() == 0) chk("unexpected_send_resp_UART", 1, 0);
        else begin
          chk("resp", resp, resp_q.pop_front());
          exp_idx = idx_q.pop_front();
          if (resp_q.size() == 0) done = 1;
        end
      end
      chk("mv_indx", mv_indx, exp_idx);
      if (done) break;
      chk("clr_cmd_rdy_UART_blocked", clr_cmd_rdy_UART, 1'b0);
      cp.clr_cmd_rdy = 1'b0;
      cp.send_resp = 1'b0;
      start_tour = 1'b0;
      cmd_rdy_UART = 1'($urandom);
      cmd_UART = 16'($urandom);
      case (phase)
        0: if (cp.cmd_rdy) begin
          if (cmd_q.size() == 0) chk("unexpected_cmd_rdy", 1, 0);
          else begin
            cur = cmd_q.pop_front();
            chk("cmd", cp.cmd, cur);
            obs_q.push_back(cp.cmd);
            if (legs == rst_leg) begin
              do_reset();
              done = 1;
            end else begin
              legs++;
              dly = $urandom_range(0, 3);
              phase = 1;
            end
          end
        end
        1: begin
          chk("cmd_held", {cp.cmd_rdy, cp.cmd}, {1'b1, cur});
          if (dly == 0) begin
            cp.clr_cmd_rdy = 1'b1;
            cp.send_resp = 1'($urandom_range(0, 1));
            dly = $urandom_range(1, 4);
            phase = 2;
          end else dly--;
        end
        default: begin
          chk("cmd_rdy_dropped", cp.cmd_rdy, 1'b0);
          if (legs % 2 == 0) start_tour = 1'($urandom_range(0, 1));
          if (dly == 0) begin
            cp.send_resp = 1'b1;
            phase = 0;
          end else dly--;
        end
      endcase
      if (done) break;
      @(posedge clk); #1;
    end
    if (!done) chk("tour_timeout", 0, 1);
    cp.clr_cmd_rdy = 1'b0;
    cp.send_resp = 1'b0;
    cmd_rdy_UART = 1'b0;
    start_tour = 1'b0;
  endtask

  task automatic idle_passthrough(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      cmd_UART = 16'($urandom);
      cmd_rdy_UART = 1'($urandom);
      cp.clr_cmd_rdy = 1'($urandom);
      cp.send_resp = 1'($urandom);
      #1;
      chk("idle_cmd", cp.cmd, cmd_UART);
      chk("idle_cmd_rdy", cp.cmd_rdy, cmd_rdy_UART);
      chk("idle_clr_uart", clr_cmd_rdy_UART, cp.clr_cmd_rdy);
      chk("idle_send_resp_uart", send_resp_UART, cp.send_resp);
      chk("idle_resp", resp, 8'hA5);
    end
    cmd_rdy_UART = 1'b0; cp.clr_cmd_rdy = 1'b0; cp.send_resp = 1'b0;
  endtask

  task automatic random_tour_moves();
    logic [7:0] m;
    for (int i = 0; i < 32; i++) begin
      m = 8'($urandom);
      if ($urandom_range(0, 3) != 0) m = 8'h01 << $urandom_range(0, 7);
      if (m == 8'h00) m = 8'h80;
      tour_moves[i] = m;
    end
  endtask

  initial begin
    logic [15:0] vc, hc;
    cp.clr_cmd_rdy = 1'b0;
    cp.send_resp = 1'b0;
    for (int i = 0; i < 32; i++) tour_moves[i] = 8'h01;

    // Pin the reference model itself
    model_legs(8'h01, vc, hc);
    chk("model_bit0_v", vc, 16'h4002); chk("model_bit0_h", hc, 16'h5BF1);
    model_legs(8'h04, vc, hc);
    chk("model_bit2_v", vc, 16'h4001); chk("model_bit2_h", hc, 16'h53F2);
    model_legs(8'h60, vc, hc);
    chk("model_multihot_v", vc, 16'h47F2); chk("model_multihot_h", hc, 16'h5BF1);

    // Reset state
    #12;
    chk("rst_mv_indx", mv_indx, 5'd0);
    chk("rst_cmd_rdy", cp.cmd_rdy, 1'b0);
    chk("rst_clr_uart", clr_cmd_rdy_UART, 1'b0);
    chk("rst_send_resp_uart", send_resp_UART, 1'b0);
    chk("rst_resp", resp, 8'hA5);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Idle passthrough, literal case first
    @(posedge clk); #1;
    cmd_UART = 16'h2000; cmd_rdy_UART = 1'b1; cp.clr_cmd_rdy = 1'b1;
    #1;
    chk("pass_cmd_2000", cp.cmd, 16'h2000);
    chk("pass_cmd_rdy", cp.cmd_rdy, 1'b1);
    chk("pass_clr_pulse", clr_cmd_rdy_UART, 1'b1);
    idle_passthrough(20);

    // Directed decode sweep ending in a zero move (abort)
    tour_moves[0] = 8'h01; tour_moves[1] = 8'h04;
    tour_moves[2] = 8'h40; tour_moves[3] = 8'h00;
    @(posedge clk); #1;
    run_tour(-1);
    chk("sweep_cmd_count", obs_q.size(), 6);
    if (obs_q.size() == 6) begin
      chk("sweep_m0_v", obs_q[0], 16'h4002); chk("sweep_m0_h", obs_q[1], 16'h5BF1);
      chk("sweep_m1_v", obs_q[2], 16'h4001); chk("sweep_m1_h", obs_q[3], 16'h53F2);
      chk("sweep_m2_v", obs_q[4], 16'h47F1); chk("sweep_m2_h", obs_q[5], 16'h5BF2);
    end
    idle_passthrough(5);

    // Full random tours; completion leaves IDLE with mv_indx held at 23
    for (int t = 0; t < 3; t++) begin
      random_tour_moves();
      @(posedge clk); #1;
      run_tour(-1);
      @(posedge clk); #1;
      #1;
      chk("post_tour_cmd_rdy", cp.cmd_rdy, 1'b0);
      chk("post_tour_mv_indx", mv_indx, 5'd23);
      idle_passthrough(4);
    end

    // Asynchronous reset in the horizontal leg of move 1
    random_tour_moves();
    @(posedge clk); #1;
    run_tour(3);
    idle_passthrough(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
